fetch_unit: RTL

Instruction fetch stage feeding the decode/control stage of the RISC-V core. Owns the fetch PC, issues in-order requests to instruction memory over a valid/ready request channel, and buffers returned words in a 2-entry FIFO. Each buffered word is presented downstream with its PC, PC+4 and pre-sliced opcode/funct3/funct7 fields. Applies taken-branch/jump redirects from execute by flushing the buffer and discarding stale in-flight responses.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order requests to instruction memory and buffers
// the returned words in a 2-entry FIFO. Redirects flush the buffer and drop stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7
);

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  logic [31:0] fpc_q, fpc_d;
  logic        run_q, run_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        fifo_head_q, fifo_head_d;
  logic        ipq_head_q, ipq_head_d;
  logic [31:0] fifo_word_q [2];
  logic [31:0] fifo_word_d [2];
  logic [31:0] fifo_pc_q [2];
  logic [31:0] fifo_pc_d [2];
  logic [31:0] ipq_pc_q [2];
  logic [31:0] ipq_pc_d [2];

  logic        req_fire;
  logic        rsp_take;
  logic        rsp_push;
  logic        pop;
  logic        fifo_tail;
  logic        ipq_tail;
  logic [2:0]  occupancy;

  // run_q keeps the request channel quiet until the first edge after reset release
  always_comb begin
    occupancy      = {1'b0, inflight_q} + {1'b0, cnt_q};
    imem_req_valid = run_q && !redirect_valid && (occupancy < 3'd2);
    imem_req_addr  = fpc_q & PC_MASK;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and simply ignored
    rsp_take       = imem_rsp_valid && (inflight_q != 2'd0);
    rsp_push       = rsp_take && (drop_q == 2'd0) && !redirect_valid;
    instr_valid    = (cnt_q != 2'd0);
    pop            = instr_valid && instr_ready;
    fifo_tail      = fifo_head_q ^ cnt_q[0];
    ipq_tail       = ipq_head_q ^ inflight_q[0];
  end

  // Next-state for PC, counters and the two small queues
  always_comb begin
    run_d       = 1'b1;
    inflight_d  = inflight_q + {1'b0, req_fire} - {1'b0, rsp_take};
    ipq_head_d  = ipq_head_q ^ rsp_take;
    fifo_head_d = fifo_head_q ^ pop;
    ipq_pc_d    = ipq_pc_q;
    fifo_word_d = fifo_word_q;
    fifo_pc_d   = fifo_pc_q;

    if (req_fire) begin
      ipq_pc_d[ipq_tail] = fpc_q & PC_MASK;
    end else begin
      ipq_pc_d = ipq_pc_q;
    end

    if (rsp_push) begin
      fifo_word_d[fifo_tail] = imem_rsp_data;
      fifo_pc_d[fifo_tail]   = ipq_pc_q[ipq_head_q];
    end else begin
      fifo_word_d = fifo_word_q;
      fifo_pc_d   = fifo_pc_q;
    end

    // Every request still outstanding after a redirect belongs to the old path
    if (redirect_valid) begin
      fpc_d  = redirect_target & PC_MASK;
      cnt_d  = 2'd0;
      drop_d = inflight_d;
    end else begin
      if (req_fire) begin
        fpc_d = fpc_q + 32'd4;
      end else begin
        fpc_d = fpc_q;
      end
      cnt_d = cnt_q + {1'b0, rsp_push} - {1'b0, pop};
      if (rsp_take && (drop_q != 2'd0)) begin
        drop_d = drop_q - 2'd1;
      end else begin
        drop_d = drop_q;
      end
    end
  end

  // Head-of-FIFO presentation; everything reads zero when the buffer is empty
  always_comb begin
    if (instr_valid) begin
      instr         = fifo_word_q[fifo_head_q];
      instr_pc      = fifo_pc_q[fifo_head_q];
      instr_pcplus4 = fifo_pc_q[fifo_head_q] + 32'd4;
    end else begin
      instr         = 32'd0;
      instr_pc      = 32'd0;
      instr_pcplus4 = 32'd0;
    end
    opcode = instr[6:0];
    funct3 = instr[14:12];
    funct7 = instr[30];
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q          <= RESET_PC;
      run_q          <= 1'b0;
      inflight_q     <= 2'd0;
      drop_q         <= 2'd0;
      cnt_q          <= 2'd0;
      fifo_head_q    <= 1'b0;
      ipq_head_q     <= 1'b0;
      fifo_word_q[0] <= 32'd0;
      fifo_word_q[1] <= 32'd0;
      fifo_pc_q[0]   <= 32'd0;
      fifo_pc_q[1]   <= 32'd0;
      ipq_pc_q[0]    <= 32'd0;
      ipq_pc_q[1]    <= 32'd0;
    end else begin
      fpc_q          <= fpc_d;
      run_q          <= run_d;
      inflight_q     <= inflight_d;
      drop_q         <= drop_d;
      cnt_q          <= cnt_d;
      fifo_head_q    <= fifo_head_d;
      ipq_head_q     <= ipq_head_d;
      fifo_word_q[0] <= fifo_word_d[0];
      fifo_word_q[1] <= fifo_word_d[1];
      fifo_pc_q[0]   <= fifo_pc_d[0];
      fifo_pc_q[1]   <= fifo_pc_d[1];
      ipq_pc_q[0]    <= ipq_pc_d[0];
      ipq_pc_q[1]    <= ipq_pc_d[1];
    end
  end

endmodule
